// File: rtl/alu_nibble_sequencer.sv
// Drives a 4-bit ALU one nibble per clock (LSB first), chaining the carry through a register.
// Latency NIBBLES+1 cycles from start to done; start is only taken while ready (IDLE) is high.
module alu_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 ready,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   input  logic [3:0]           op_s,
   input  logic                 op_m,
   input  logic                 op_cin,
   output logic [3:0]           alu_A,
   output logic [3:0]           alu_B,
   output logic [3:0]           alu_S,
   output logic                 alu_M,
   output logic                 alu_Pin,
   input  logic [3:0]           alu_R,
   input  logic [3:0]           alu_P,
   output logic [4*NIBBLES-1:0] result,
   output logic                 carry_out,
   output logic                 zero,
   output logic                 done,
   output logic                 busy
);

   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [NIBBLES-1:0][3:0] a_lat;
   logic [NIBBLES-1:0][3:0] b_lat;
   logic [NIBBLES-1:0][3:0] res_q;
   logic [NIBBLES-1:0][3:0] res_nxt;
   logic [3:0]              s_lat;
   logic                    m_lat;
   logic                    carry_q;
   logic                    cout_q;
   logic                    zero_q;
   logic [IW-1:0]           idx;
   logic                    last;
   logic                    p_unused;

   assign last     = (idx == LAST);
   assign p_unused = ^alu_P[2:0];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Result with the current nibble merged in; zero must see it before it is registered.
   always_comb begin
      res_nxt      = res_q;
      res_nxt[idx] = alu_R;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_lat   <= '0;
         b_lat   <= '0;
         s_lat   <= '0;
         m_lat   <= 1'b0;
         carry_q <= 1'b0;
         idx     <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_lat   <= op_a;
               b_lat   <= op_b;
               s_lat   <= op_s;
               m_lat   <= op_m;
               carry_q <= op_cin;
               idx     <= '0;
               res_q   <= '0;
               zero_q  <= 1'b0;
            end
            RUN: begin
               res_q   <= res_nxt;
               carry_q <= alu_P[3];
               if (last) begin
                  cout_q <= alu_P[3];
                  zero_q <= (res_nxt == '0);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign alu_A     = (state == RUN) ? a_lat[idx] : 4'h0;
   assign alu_B     = (state == RUN) ? b_lat[idx] : 4'h0;
   assign alu_S     = s_lat;
   assign alu_M     = m_lat;
   assign alu_Pin   = carry_q;
   assign ready     = (state == IDLE);
   assign busy      = (state == RUN) || (state == DONE);
   assign done      = (state == DONE);
   assign result    = res_q;
   assign carry_out = cout_q;
   assign zero      = zero_q;

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Sequences the 4-bit serial ALU (A, B, S, M, Pin in; R, P out) over a wide operand, one nibble per clock, LSB nibble first.
- Carry is chained between nibbles through a register.
- Accepts one operation through a start/ready handshake and returns the full-width result, carry out and a zero flag with a one-cycle done pulse.
- Sits between the control unit and the ALU instance; it is the only driver of the ALU inputs.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operation request; accepted only when ready=1.
- ready  output  1  high in IDLE only.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- op_s  input  4  ALU function select.
- op_m  input  1  ALU mode (1 = logic, 0 = arithmetic).
- op_cin  input  1  initial carry, applied to nibble 0 Pin.
- alu_A  output  4  nibble of A to the ALU.
- alu_B  output  4  nibble of B to the ALU.
- alu_S  output  4  function select to the ALU.
- alu_M  output  1  mode to the ALU.
- alu_Pin  output  1  carry into the ALU.
- alu_R  input  4  ALU result nibble (combinational from alu_* outputs).
- alu_P  input  4  ALU ripple carries; alu_P[3] is the nibble carry out.
- result  output  W  assembled result.
- carry_out  output  1  carry out of the last nibble.
- zero  output  1  result == 0.
- done  output  1  one-cycle pulse; result valid.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - State IDLE, ready=1, busy=0, done=0.
  - result=0, carry_out=0, zero=0.
  - Nibble index=0, carry register=0.
  - Latched A/B/S/M = 0; alu_* outputs all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches op_a, op_b, op_s, op_m, and op_cin into the carry register.
  - Clears index and result; goes to RUN.
  - start=0: stay in IDLE.
- RUN, at index i:
  - alu_A = A_lat[4i+3:4i], alu_B = B_lat[4i+3:4i], alu_S = S_lat, alu_M = M_lat, alu_Pin = carry register.
  - On the clock edge: result[4i+3:4i] <= alu_R; carry register <= alu_P[3]; i <= i+1.
  - At i = NIBBLES-1: carry_out <= alu_P[3] and go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - zero = (result == 0), registered on entry to DONE.
  - Then return to IDLE.
- Outputs persist: result, carry_out and zero hold until the next accepted start, which clears result and zero.
- Latency: start accepted at cycle 0; RUN occupies cycles 1..NIBBLES; done=1 at cycle NIBBLES+1; ready=1 again at cycle NIBBLES+2.
- Carry polarity: alu_P[3] is fed back to alu_Pin unmodified; no inversion in this block.
- Logic mode: carry is chained identically when op_m=1; the ALU ignores it.
- Idle drive: outside RUN, alu_A and alu_B are driven 0; alu_S, alu_M and alu_Pin hold their latched values.
- start while busy: ignored, no effect on latched operands; start in DONE is also ignored.
- start held high continuously: back-to-back operations every NIBBLES+2 cycles.
- Operand changes after acceptance: op_* changes have no effect on the running operation.
- Reset mid-RUN or in DONE: immediate return to reset values; no done pulse is generated.
- Index wrap: the index never exceeds NIBBLES-1; no wrap-around occurs.

Test Plan:
Bench ALU stub: R = A+B+Pin mod 16, P[3] = carry, NIBBLES=4.
1. op_a=16'h1234, op_b=16'h0FFF, op_cin=0, start pulse -> alu_A sequence 4,3,2,1 in cycles 1-4; done at cycle 5; result=16'h2233, carry_out=0, zero=0.
2. op_a=16'hFFFF, op_b=16'h0001, op_cin=0 -> alu_Pin sequence 0,1,1,1; result=16'h0000, carry_out=1, zero=1.
3. op_a=16'h00FF, op_b=16'h0000, op_cin=1 -> result=16'h0100, carry_out=0; alu_Pin at nibble 0 = 1.
4. Start with 16'h1111/16'h1111; assert start again with other operands at cycles 2 and 5 -> both ignored; result=16'h2222; ready returns at cycle 6; a start then is accepted.
5. rst=1 at cycle 3 of RUN -> next cycle all outputs at reset values, ready=1, no done pulse; a fresh op then completes normally.
6. op_m=1, op_s=4'hA with stub R=A^B -> op_a=16'hF0F0, op_b=16'hFF00 gives result=16'h0FF0; S/M held constant on alu_S/alu_M across all RUN cycles.
